// File: rtl/ps2_key_decoder_pkg.sv
// Shared definitions for the PS/2 set-2 key decoder.
//   PS2_BREAK / PS2_EXT : scancode prefix bytes
//   KEY_TABLE           : make codes of the mapped keys, index = key number
//   ps2_state_e         : prefix-tracking FSM states
//   idx_width()         : width of a key index (minimum 1 bit)
package ps2_key_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  localparam int unsigned KEY_TABLE_LEN = 4;
  // Entry i holds the make code for key i: F, Q, H, X.
  localparam logic [KEY_TABLE_LEN-1:0][7:0] KEY_TABLE = {8'h22, 8'h33, 8'h15, 8'h2B};

  typedef enum logic [1:0] {
    StIdle,
    StBrk,
    StExt,
    StExtBrk
  } ps2_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Byte-in / character-out handshake bundle of the key decoder.
//   scancode, scancode_valid : byte strobe from the PS/2 receiver
//   char_ready               : renderer accepts the head character
//   char_valid               : a decoded character is available
//   start_address_out        : glyph ROM start address of that character
// master = receiver/renderer side, slave = decoder side.
interface ps2_key_decoder_if #(
  parameter int unsigned ADDR_W = 6
) ();

  logic [7:0]        scancode;
  logic              scancode_valid;
  logic              char_ready;
  logic              char_valid;
  logic [ADDR_W-1:0] start_address_out;

  modport master (
    output scancode, scancode_valid, char_ready,
    input  char_valid, start_address_out
  );

  modport slave (
    input  scancode, scancode_valid, char_ready,
    output char_valid, start_address_out
  );

endinterface

// File: rtl/ps2_key_decoder_key_fifo.sv
// key_fifo: synchronous FIFO with full/empty flags.
//   vga_clk, rst_n : clock, asynchronous active-low reset
//   clear          : synchronous flush
//   push/push_data : write request; accepted when not full or when popping
//   pop/pop_data   : read request (ignored when empty), head data
//   full, empty    : occupancy flags
// DEPTH must be a power of two >= 2.
module key_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic             vga_clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Extra MSB distinguishes full from empty when the indices match.
  logic [PTR_W:0]   wr_q, rd_q;
  logic             do_push, do_pop;

  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q[PTR_W] != rd_q[PTR_W]) && (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
  assign do_pop   = pop && !empty;
  // When full, a same-cycle pop frees the slot being written.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_q[PTR_W-1:0]];

  always_ff @(posedge vga_clk) begin
    if (do_push) begin
      mem[wr_q[PTR_W-1:0]] <= push_data;
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (clear) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + {{PTR_W{1'b0}}, 1'b1};
      if (do_pop)  rd_q <= rd_q + {{PTR_W{1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 set-2 scancodes -> glyph ROM start addresses.
//   vga_clk, rst_n : pixel clock, asynchronous active-low reset
//   clear          : synchronous flush of FIFO, key_held and overflow
//   bus (slave)    : scancode byte strobe in, character valid/ready out
//   key_held       : bit i set while key i is pressed
//   overflow       : sticky, a decoded character was dropped
// Build option: PS2_TYPEMATIC_EN makes every make code of a held key push
// again (auto-repeat); by default a break is needed between pushes.
module ps2_key_decoder
  import ps2_key_pkg::*;
#(
  parameter int unsigned NUM_KEYS   = 4,
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned GLYPH_LOG2 = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                vga_clk,
  input  logic                rst_n,
  input  logic                clear,
  ps2_key_decoder_if.slave    bus,
  output logic [NUM_KEYS-1:0] key_held,
  output logic                overflow
);

  localparam int unsigned IDX_W      = idx_width(NUM_KEYS);
  localparam int unsigned NUM_MAPPED = (NUM_KEYS < KEY_TABLE_LEN) ? NUM_KEYS : KEY_TABLE_LEN;
  localparam int unsigned SH_W       = IDX_W + GLYPH_LOG2;

  ps2_state_e          state_q;
  logic [NUM_KEYS-1:0] key_held_q;
  logic                overflow_q;

  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic             make_push;
  logic             push, pop, full, empty;
  logic [IDX_W-1:0] head;
  logic [SH_W-1:0]  head_shifted;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < NUM_MAPPED; i++) begin
      if (!hit && bus.scancode == KEY_TABLE[i]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

`ifdef PS2_TYPEMATIC_EN
  assign make_push = 1'b1;
`else
  // Typematic repeats of a held key only refresh key_held.
  assign make_push = !key_held_q[hit_idx];
`endif

  // Push decided from the incoming byte so the character is visible next cycle.
  assign push = bus.scancode_valid && (state_q == StIdle) && hit && make_push;
  assign pop  = !empty && bus.char_ready;

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      key_held_q <= '0;
    end else if (clear) begin
      state_q    <= StIdle;
      key_held_q <= '0;
    end else if (bus.scancode_valid) begin
      unique case (state_q)
        StIdle: begin
          if (bus.scancode == PS2_BREAK) begin
            state_q <= StBrk;
          end else if (bus.scancode == PS2_EXT) begin
            state_q <= StExt;
          end else if (hit) begin
            key_held_q[hit_idx] <= 1'b1;
          end
        end
        StBrk: begin
          if (hit) key_held_q[hit_idx] <= 1'b0;
          state_q <= StIdle;
        end
        // No extended keys are mapped; their bytes are dropped.
        StExt: begin
          state_q <= (bus.scancode == PS2_BREAK) ? StExtBrk : StIdle;
        end
        StExtBrk: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (clear) begin
      overflow_q <= 1'b0;
    end else if (push && full && !pop) begin
      overflow_q <= 1'b1;
    end
  end

  key_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .vga_clk   (vga_clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .push      (push),
    .push_data (hit_idx),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

  assign head_shifted          = SH_W'(head) << GLYPH_LOG2;
  assign bus.char_valid        = !empty;
  assign bus.start_address_out = empty ? '0 : ADDR_W'(head_shifted);
  assign key_held              = key_held_q;
  assign overflow              = overflow_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder (default parameters).
// Expected glyph addresses are queued when a pushing make code is driven and
// compared whenever the DUT hands a character to the renderer.
module tb_ps2_key_decoder;

`ifdef PS2_TYPEMATIC_EN
  localparam bit TYP = 1'b1;
`else
  localparam bit TYP = 1'b0;
`endif

  logic       vga_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic       clear   = 1'b0;
  logic [3:0] key_held;
  logic       overflow;

  ps2_key_decoder_if #(.ADDR_W(6)) bus ();

  ps2_key_decoder #(
    .NUM_KEYS   (4),
    .ADDR_W     (6),
    .GLYPH_LOG2 (4),
    .FIFO_DEPTH (4)
  ) dut (
    .vga_clk  (vga_clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .bus      (bus),
    .key_held (key_held),
    .overflow (overflow)
  );

  always #5 vga_clk = ~vga_clk;

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q [$];

  typedef struct {
    logic [7:0] code;
    bit         push;
    int         idx;
    logic [3:0] held;
  } vec_t;
  vec_t vecs [$];

  function automatic logic [5:0] addr_of(input int idx);
    return 6'(idx * 16);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every character taken by the renderer must be the oldest expected one.
  always @(negedge vga_clk) begin
    if (rst_n && bus.char_valid && bus.char_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected actual=%b expected=none", bus.start_address_out);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        if (bus.start_address_out !== e) begin
          errors++;
          $display("FAIL pop_addr actual=%b expected=%b", bus.start_address_out, e);
        end
      end
    end
  end

  task automatic send(input logic [7:0] c);
    @(posedge vga_clk); #1;
    bus.scancode       = c;
    bus.scancode_valid = 1'b1;
    @(posedge vga_clk); #1;
    bus.scancode_valid = 1'b0;
  endtask

  task automatic burst(input logic [7:0] codes [$]);
    foreach (codes[k]) begin
      @(posedge vga_clk); #1;
      bus.scancode       = codes[k];
      bus.scancode_valid = 1'b1;
    end
    @(posedge vga_clk); #1;
    bus.scancode_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    @(posedge vga_clk); #1;
    clear = 1'b1;
    @(posedge vga_clk); #1;
    clear = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge vga_clk);
      n++;
    end
    @(posedge vga_clk); #1;
    chk({name, "_pending"}, exp_q.size(), 0);
    chk({name, "_valid"}, bus.char_valid, 0);
  endtask

  task automatic add(input logic [7:0] c, input bit p, input int i, input logic [3:0] h);
    vec_t v;
    v.code = c; v.push = p; v.idx = i; v.held = h;
    vecs.push_back(v);
  endtask

  initial begin
    logic [7:0] seq [$];

    bus.scancode       = 8'h00;
    bus.scancode_valid = 1'b0;
    bus.char_ready     = 1'b0;

    add(8'h33, 1'b1, 2, 4'b0100);
    add(8'hF0, 1'b0, 0, 4'b0100);
    add(8'h33, 1'b0, 0, 4'b0000);
    add(8'h22, 1'b1, 3, 4'b1000);
    add(8'hF0, 1'b0, 0, 4'b1000);
    add(8'h22, 1'b0, 0, 4'b0000);
    add(8'h15, 1'b1, 1, 4'b0010);
    add(8'h15, TYP,  1, 4'b0010);
    add(8'h15, TYP,  1, 4'b0010);
    add(8'hF0, 1'b0, 0, 4'b0010);
    add(8'h15, 1'b0, 0, 4'b0000);
    add(8'h33, 1'b1, 2, 4'b0100);
    add(8'hE0, 1'b0, 0, 4'b0100);
    add(8'h2B, 1'b0, 0, 4'b0100);
    add(8'hE0, 1'b0, 0, 4'b0100);
    add(8'hF0, 1'b0, 0, 4'b0100);
    add(8'h33, 1'b0, 0, 4'b0100);
    add(8'h2B, 1'b1, 0, 4'b0101);
    add(8'hF0, 1'b0, 0, 4'b0101);
    add(8'h2B, 1'b0, 0, 4'b0100);
    add(8'hF0, 1'b0, 0, 4'b0100);
    add(8'h33, 1'b0, 0, 4'b0000);

    // Reset state
    #12;
    chk("rst_valid", bus.char_valid, 0);
    chk("rst_addr", bus.start_address_out, 0);
    chk("rst_held", key_held, 0);
    chk("rst_ovf", overflow, 0);
    @(posedge vga_clk); #1;
    rst_n = 1'b1;

    // First make: visible the cycle after the strobe
    exp_q.push_back(addr_of(0));
    send(8'h2B);
    chk("first_valid", bus.char_valid, 1);
    chk("first_addr", bus.start_address_out, 6'b000000);
    chk("first_held", key_held, 4'b0001);
    @(posedge vga_clk); #1;
    chk("first_hold_stable", bus.start_address_out, 6'b000000);
    bus.char_ready = 1'b1;
    @(posedge vga_clk); #1;
    chk("first_popped", bus.char_valid, 0);
    send(8'hF0);
    send(8'h2B);
    chk("first_break_held", key_held, 4'b0000);

    // Table-driven decode with the renderer always ready
    foreach (vecs[k]) begin
      if (vecs[k].push) exp_q.push_back(addr_of(vecs[k].idx));
      send(vecs[k].code);
      chk($sformatf("vec%0d_held", k), key_held, vecs[k].held);
    end
    wait_drain("table");

    // Overflow: five presses back-to-back, renderer stalled
    bus.char_ready = 1'b0;
    seq = '{8'h2B, 8'hF0, 8'h2B, 8'h15, 8'hF0, 8'h15, 8'h33, 8'hF0, 8'h33,
            8'h22, 8'hF0, 8'h22, 8'h2B, 8'hF0, 8'h2B};
    for (int i = 0; i < 4; i++) exp_q.push_back(addr_of(i));
    burst(seq);
    chk("ovf_flag", overflow, 1);
    chk("ovf_valid", bus.char_valid, 1);
    chk("ovf_head", bus.start_address_out, 6'b000000);
    chk("ovf_held", key_held, 4'b0000);
    pulse_clear();
    chk("clr_valid", bus.char_valid, 0);
    chk("clr_addr", bus.start_address_out, 0);
    chk("clr_ovf", overflow, 0);

    // Fill to full, then push and pop in the same cycle
    seq = '{8'h2B, 8'h15, 8'h33, 8'h22};
    for (int i = 0; i < 4; i++) exp_q.push_back(addr_of(i));
    burst(seq);
    chk("full_held", key_held, 4'b1111);
    chk("full_ovf", overflow, 0);
    send(8'hF0);
    send(8'h2B);
    chk("full_break_held", key_held, 4'b1110);
    exp_q.push_back(addr_of(0));
    @(posedge vga_clk); #1;
    bus.scancode       = 8'h2B;
    bus.scancode_valid = 1'b1;
    bus.char_ready     = 1'b1;
    @(posedge vga_clk); #1;
    bus.scancode_valid = 1'b0;
    bus.char_ready     = 1'b0;
    chk("pushpop_ovf", overflow, 0);
    chk("pushpop_head", bus.start_address_out, 6'b010000);
    chk("pushpop_held", key_held, 4'b1111);

    // Clear wins over a same-cycle make code
    @(posedge vga_clk); #1;
    clear              = 1'b1;
    bus.scancode       = 8'h15;
    bus.scancode_valid = 1'b1;
    @(posedge vga_clk); #1;
    clear              = 1'b0;
    bus.scancode_valid = 1'b0;
    exp_q.delete();
    chk("clrprio_valid", bus.char_valid, 0);
    chk("clrprio_held", key_held, 4'b0000);
    chk("clrprio_ovf", overflow, 0);

    // Reset after a break prefix discards both the prefix and the FIFO
    exp_q.push_back(addr_of(2));
    send(8'h33);
    send(8'hF0);
    #3;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("midrst_valid", bus.char_valid, 0);
    chk("midrst_addr", bus.start_address_out, 0);
    chk("midrst_held", key_held, 0);
    @(posedge vga_clk); #1;
    rst_n = 1'b1;
    bus.char_ready = 1'b1;
    exp_q.push_back(addr_of(3));
    send(8'h22);
    chk("postrst_held", key_held, 4'b1000);
    wait_drain("postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Parametrised PS/2 set-2 scancode decoder that turns a stream of received bytes into glyph ROM start addresses for the VGA character renderer. It tracks make/break/extended prefixes with a state machine, keeps a per-key "held" mask, suppresses typematic repeats, and buffers decoded characters in a small FIFO with a valid/ready handshake toward the renderer. It sits between the PS/2 receiver (byte + strobe) and the VGA text/glyph path, running entirely on the pixel clock.

## Interface
- NUM_KEYS, 4: number of mapped keys (table entries), 1..2^(ADDR_W-GLYPH_LOG2)
- ADDR_W, 6: width of glyph ROM start address
- GLYPH_LOG2, 4: log2 of rows per glyph; start address = key index << GLYPH_LOG2
- FIFO_DEPTH, 4: output buffer depth, power of two, >= 2

- vga_clk  in  1  sole clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- scancode  in  8  received byte, sampled only when scancode_valid=1
- scancode_valid  in  1  one-cycle strobe from PS/2 receiver
- char_ready  in  1  renderer accepts head entry this cycle
- clear  in  1  synchronous: flush FIFO, clear key_held and overflow
- char_valid  out  1  FIFO non-empty
- start_address_out  out  ADDR_W  glyph start address of FIFO head
- key_held  out  NUM_KEYS  bit i = key i currently pressed
- overflow  out  1  sticky: a decoded character was dropped

## Operation
- Key table (index: code): 0: 8'h2B (F), 1: 8'h15 (Q), 2: 8'h33 (H), 3: 8'h22 (X); entries beyond NUM_KEYS ignored.
- FSM states: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0). Advances only on scancode_valid.
  - IDLE: F0->BRK; E0->EXT; mapped code i -> make(i), stay IDLE; other -> stay IDLE.
  - BRK: mapped code i -> key_held[i]<=0; any byte -> IDLE (F0/E0 inside BRK treated as unmapped).
  - EXT: F0->EXT_BRK; any other byte -> IDLE, discarded (no extended keys mapped).
  - EXT_BRK: any byte -> IDLE, discarded.
- make(i): key_held[i]<=1; push index i if key_held[i] was 0 (repeat suppression, see Configuration).
- FIFO stores key indices (width clog2(NUM_KEYS), min 1). Pop when char_valid && char_ready.
- Push while full and no pop in same cycle: entry dropped, overflow<=1. Push and pop together when full: both happen, no overflow.
- clear has priority over a same-cycle push/pop/FSM update: FIFO empty, key_held=0, overflow=0, FSM->IDLE.
- start_address_out = head index << GLYPH_LOG2, zero-extended/truncated to ADDR_W; holds 0 when empty.

## Timing
- Reset (async assert, sync release): FSM IDLE, FIFO empty, char_valid=0, start_address_out=0, key_held=0, overflow=0.
- Latency: scancode_valid with mapped make code in cycle N (FIFO empty) -> char_valid=1 and address valid in N+1.
- key_held updates in cycle N+1 after the accepted byte.
- Pop in cycle N -> next entry (or char_valid=0) visible in N+1.
- Back-to-back scancode_valid every cycle supported; no throughput limit.
- start_address_out/char_valid stable while char_valid=1 and char_ready=0.
- Reset mid-sequence (e.g. after F0) discards prefix; next byte decoded from IDLE.

## Configuration
- PS2_TYPEMATIC_EN defined: every make code of a mapped key pushes, even if already held (auto-repeat reaches renderer).
- Undefined (default): make of an already-held key only refreshes key_held, no push; a push requires a break in between.

## Structure
- Package ps2_key_pkg: PS2_BREAK=8'hF0, PS2_EXT=8'hE0, key code table constant, FSM state enum.
- Sub-module key_fifo: parametrised synchronous FIFO (width, depth), full/empty, simultaneous push/pop when full.

## Test plan
- Reset, then 2B -> char_valid=1 next cycle, start_address_out=6'b000000, key_held=4'b0001.
- 33, F0 33, 22 with char_ready=1 -> addresses 6'b100000 then 6'b110000; key_held ends 4'b1000.
- 15 15 15 without define -> one entry 6'b010000; with PS2_TYPEMATIC_EN -> three entries.
- E0 2B, then E0 F0 2B -> no push, key_held unchanged, FSM back in IDLE; next 2B pushes 6'b000000.
- char_ready=0, make/break 5 distinct presses (depth 4) -> 4 entries, overflow=1; push+pop when full -> no overflow; clear -> all zero.
- Assert rst_n low after F0 mid-sequence -> outputs reset; following 22 pushes 6'b110000.
